// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
//
// Turns single commands from a valid/ready command port into APB transfers
// and returns one response per transfer on a valid/ready response port.
// A transfer walks IDLE -> SETUP -> ACCESS -> RESP. The block leaves ACCESS
// when the completer raises PREADY, or when the completer has held PREADY
// low for TIMEOUT cycles (TIMEOUT = 0 means wait forever).
//
// Handshakes: a beat moves on a rising PCLK edge where valid and ready are
// both high. A producer holds valid and its payload until that edge. The
// response payload stays stable while rsp_valid is high and rsp_ready is low.
//
// Ports
//   PCLK, PRESETn             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write/addr/wdata      command payload (1 = write)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/err/timeout     response payload (rdata is 0 for writes/timeouts)
//   PADDR..PENABLE            registered APB requester outputs
//   PRDATA/PREADY/PSLVERR     APB completer inputs
//   fsm_state                 current FSM state, for observation
// ---------------------------------------------------------------------------
module apb_requester #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          live;         // low until the first edge after reset release
    logic          accept;
    logic          timeout_hit;

    always_comb begin
        cmd_ready   = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        state_next  = state;

        // cmd_ready stays low in the cycle reset releases.
        cmd_ready = live && ((state == IDLE) || ((state == RESP) && rsp_ready));
        accept    = cmd_valid && cmd_ready;

        // This wait cycle would be the TIMEOUT-th one.
        timeout_hit = (TIMEOUT > 0) && !PREADY &&
                      ((32'(wait_cnt) + 32'd1) == TIMEOUT);

        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
            RESP: begin
                if (rsp_ready) state_next = accept ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            live        <= 1'b0;
            wait_cnt    <= '0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;

            if (accept) begin
                PADDR    <= cmd_addr;
                PWDATA   <= cmd_wdata;
                PWRITE   <= cmd_write;
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !PREADY &&
                         (32'(wait_cnt) < TIMEOUT)) begin
                // Saturates at TIMEOUT instead of wrapping.
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata   <= PWRITE ? '0 : PRDATA;
                    rsp_err     <= PSLVERR;
                    rsp_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end

            // Bus controls are registered from the next state so they line
            // up exactly with the state they belong to.
            PSEL      <= (state_next == SETUP) || (state_next == ACCESS);
            PENABLE   <= (state_next == ACCESS);
            rsp_valid <= (state_next == RESP);
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    // Completer model controls
    int   n_wait      = 0;
    logic err_in_wait = 1'b0;
    logic err_final   = 1'b0;
    int   acc_cnt     = 0;
    logic [31:0] mem [0:4095];

    apb_requester #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .fsm_state(fsm_state)
    );

    // ---- clock ----
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---- memory completer with programmable wait states ----
    assign PREADY  = PSEL && PENABLE && (acc_cnt >= n_wait);
    assign PRDATA  = (PREADY && !PWRITE) ? mem[PADDR] : 32'hDEAD_BEEF;
    assign PSLVERR = PREADY ? err_final : (PSEL && err_in_wait);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    // ---- watchdog ----
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge and hold it for one rising edge.
    task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    // Called in the SETUP cycle; counts cycles up to and including RESP.
    task automatic wait_rsp(output int cycles, output int sel_cnt, output int en_cnt);
        cycles  = 1;
        sel_cnt = 0;
        en_cnt  = 0;
        while (!rsp_valid && cycles < 100) begin
            if (PSEL)    sel_cnt++;
            if (PENABLE) en_cnt++;
            @(negedge PCLK);
            cycles++;
        end
    endtask

    int   cyc, nsel, nen;
    logic seen_rsp;

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // ---- reset state ----
        #2;
        check("rst_psel",      PSEL,      1'b0);
        check("rst_penable",   PENABLE,   1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_paddr",     PADDR,     12'h000);
        check("rst_state",     fsm_state, 2'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check("rel_cmd_ready_before_edge", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("rel_cmd_ready_after_edge", cmd_ready, 1'b1);

        // ---- zero-wait write 0x100 <- A5A5A5A5 ----
        issue(1'b1, 12'h100, 32'hA5A5_A5A5);
        check("wr_state_setup", fsm_state, 2'd1);
        check("wr_setup_penable", PENABLE, 1'b0);
        check("wr_paddr",  PADDR,  12'h100);
        check("wr_pwdata", PWDATA, 32'hA5A5_A5A5);
        check("wr_pwrite", PWRITE, 1'b1);
        check("wr_cmd_ready_busy", cmd_ready, 1'b0);
        wait_rsp(cyc, nsel, nen);
        check("wr_latency", cyc,  3);
        check("wr_psel_cycles", nsel, 2);
        check("wr_penable_cycles", nen, 1);
        check("wr_rsp_err",   rsp_err,   1'b0);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        check("wr_resp_psel", PSEL, 1'b0);
        @(negedge PCLK);
        check("wr_back_idle", fsm_state, 2'd0);
        check("wr_idle_rsp_valid", rsp_valid, 1'b0);
        check("wr_idle_paddr_hold", PADDR, 12'h100);
        check("wr_mem", mem[12'h100], 32'hA5A5_A5A5);

        // ---- zero-wait read back ----
        issue(1'b0, 12'h100, 32'h0);
        wait_rsp(cyc, nsel, nen);
        check("rd_latency", cyc, 3);
        check("rd_rdata",   rsp_rdata,   32'hA5A5_A5A5);
        check("rd_err",     rsp_err,     1'b0);
        check("rd_timeout", rsp_timeout, 1'b0);
        @(negedge PCLK);

        // ---- 3 wait states, PSLVERR on completion and during waits ----
        n_wait = 3; err_in_wait = 1'b1; err_final = 1'b1;
        issue(1'b0, 12'h100, 32'h0);
        wait_rsp(cyc, nsel, nen);
        check("ws3_latency", cyc, 6);
        check("ws3_access_cycles", nen, 4);
        check("ws3_err",     rsp_err,     1'b1);
        check("ws3_timeout", rsp_timeout, 1'b0);
        check("ws3_rdata",   rsp_rdata,   32'hA5A5_A5A5);
        @(negedge PCLK);

        // ---- PSLVERR only during waits must be ignored ----
        n_wait = 2; err_in_wait = 1'b1; err_final = 1'b0;
        issue(1'b0, 12'h100, 32'h0);
        wait_rsp(cyc, nsel, nen);
        check("ws2_latency", cyc, 5);
        check("ws2_err_ignored", rsp_err, 1'b0);
        @(negedge PCLK);

        // ---- timeout: PREADY never rises ----
        n_wait = 1000; err_in_wait = 1'b0; err_final = 1'b0;
        issue(1'b0, 12'h100, 32'h0);
        wait_rsp(cyc, nsel, nen);
        check("to_latency", cyc, 18);
        check("to_access_cycles", nen, 16);
        check("to_timeout", rsp_timeout, 1'b1);
        check("to_err",     rsp_err,     1'b1);
        check("to_rdata",   rsp_rdata,   32'h0);
        check("to_psel_after", PSEL, 1'b0);
        @(negedge PCLK);
        n_wait = 0;

        // ---- response backpressure, then accept a new command in RESP ----
        rsp_ready = 1'b0;
        issue(1'b0, 12'h100, 32'h0);
        wait_rsp(cyc, nsel, nen);
        check("bp_latency", cyc, 3);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h104; cmd_wdata = 32'h5A5A_0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rdata_stable", rsp_rdata, 32'hA5A5_A5A5);
            check("bp_cmd_ready_low", cmd_ready, 1'b0);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_cmd_ready_in_resp", cmd_ready, 1'b1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("bp_direct_setup", fsm_state, 2'd1);
        check("bp_new_paddr", PADDR, 12'h104);
        check("bp_rsp_dropped", rsp_valid, 1'b0);
        wait_rsp(cyc, nsel, nen);
        check("bp_next_latency", cyc, 3);
        check("bp_next_err", rsp_err, 1'b0);
        @(negedge PCLK);
        check("bp_mem", mem[12'h104], 32'h5A5A_0000);

        // ---- reset in the middle of ACCESS ----
        n_wait = 5;
        issue(1'b0, 12'h104, 32'h0);
        @(negedge PCLK);
        check("mid_penable", PENABLE, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_psel",      PSEL,      1'b0);
        check("mid_rst_penable",   PENABLE,   1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_paddr",     PADDR,     12'h000);
        @(negedge PCLK);
        PRESETn = 1'b1;
        n_wait  = 0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("mid_no_rsp_after", seen_rsp, 1'b0);
        check("mid_cmd_ready", cmd_ready, 1'b1);

        // ---- traffic resumes normally ----
        issue(1'b0, 12'h104, 32'h0);
        wait_rsp(cyc, nsel, nen);
        check("post_latency", cyc, 3);
        check("post_rdata", rsp_rdata, 32'h5A5A_0000);
        @(negedge PCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, sets the APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, sets the APB data width.
REQ-003 Parameter TIMEOUT, default 16, is the maximum number of PREADY-low ACCESS cycles before abort; 0 disables the timeout.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; ports are PCLK and PRESETn.
REQ-005 PCLK  in  1  clock; all state changes on the rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-015 rsp_err  out  1  slave error or timeout.
REQ-016 rsp_timeout  out  1  transfer aborted by timeout.
REQ-017 PADDR, PWDATA, PWRITE, PSEL, PENABLE  out  ADDR_WIDTH/DATA_WIDTH/1/1/1  APB requester outputs, all registered.
REQ-018 PRDATA, PREADY, PSLVERR  in  DATA_WIDTH/1/1  APB completer inputs.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS and RESP.
REQ-020 cmd_ready SHALL be 1 in IDLE, 1 in RESP when rsp_ready=1, and 0 otherwise.
REQ-021 On acceptance, the block SHALL register cmd_addr, cmd_wdata and cmd_write onto PADDR, PWDATA and PWRITE, and go to SETUP.
REQ-022 SETUP SHALL last exactly one cycle with PSEL=1 and PENABLE=0, then go to ACCESS.
REQ-023 ACCESS SHALL drive PSEL=1 and PENABLE=1; PADDR, PWDATA and PWRITE SHALL be stable from SETUP through the end of ACCESS.
REQ-024 When PREADY=1 is sampled in ACCESS, the block SHALL capture PRDATA into rsp_rdata (reads only; writes give 0) and PSLVERR into rsp_err, clear rsp_timeout, and go to RESP.
REQ-025 PRDATA and PSLVERR SHALL be ignored in every cycle except an ACCESS cycle with PREADY=1.
REQ-026 A wait counter SHALL increment on each ACCESS cycle with PREADY=0 and clear on entry to SETUP.
REQ-027 If TIMEOUT>0 and the counter reaches TIMEOUT, the block SHALL leave ACCESS with rsp_timeout=1, rsp_err=1 and rsp_rdata=0, and go to RESP.
REQ-028 The counter width SHALL be $clog2(TIMEOUT+1), and the counter SHALL never wrap.
REQ-029 RESP SHALL drive PSEL=0, PENABLE=0 and rsp_valid=1, with the rsp_* outputs held stable until rsp_ready=1.
REQ-030 In RESP with rsp_ready=1: if cmd_valid=1, the block SHALL accept the new command and go to SETUP; otherwise it SHALL go to IDLE.
REQ-031 IDLE SHALL drive PSEL=0, PENABLE=0 and rsp_valid=0; PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-032 Latency: a command accepted at edge N SHALL give SETUP in cycle N+1, ACCESS in N+2, and rsp_valid=1 in N+3 when PREADY=1 on the first ACCESS cycle; each wait state adds one cycle.
REQ-033 Back-to-back throughput SHALL be one transfer per 3 cycles when rsp_ready=1 and there are zero wait states.

Reset
REQ-034 PRESETn=0 SHALL immediately force state IDLE, counter 0, and every output to 0, including PSEL, PENABLE, PADDR, PWDATA, PWRITE, rsp_*, and cmd_ready.
REQ-035 cmd_ready SHALL become 1 on the first PCLK edge after PRESETn deasserts.
REQ-036 A reset during SETUP, ACCESS or RESP SHALL drop the transfer with no response produced.

Verification
REQ-037 Write 0x100 <- 0xA5A5A5A5 to a zero-wait memory completer -> PSEL high for 2 cycles, PENABLE high in the 2nd only; rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-038 Read 0x100 after that write -> rsp_rdata=0xA5A5A5A5, rsp_err=0, rsp_timeout=0.
REQ-039 Read with 3 PREADY-low cycles and PSLVERR=1 on completion -> ACCESS lasts 4 cycles, rsp_err=1, rsp_timeout=0; PSLVERR=1 during the wait cycles has no effect.
REQ-040 PREADY held at 0 with TIMEOUT=16 -> abort after 16 wait cycles, rsp_timeout=1, rsp_err=1, rsp_rdata=0, PSEL=0 in the following cycle.
REQ-041 Hold rsp_ready=0 for 5 cycles, then pulse it with cmd_valid=1 -> rsp_* stable throughout, the new command is accepted in the same cycle, and SETUP follows directly.
REQ-042 Assert PRESETn=0 mid-ACCESS -> PSEL, PENABLE and rsp_valid go to 0 asynchronously; no response appears after release.
